version_rom_seq: RTL and testbench
==================================

# version_rom_seq

Sequencer that sits directly in front of the 128×16 version ROM: it drives the ROM address and consumes the ROM output word.
It serves two clients:
- single-word random reads from the register/CPU side;
- a full-table dump streamed as bytes, with a trailing checksum, to the communications transmit path.

It hides the ROM read latency and serialises all ROM accesses so that only one client owns the ROM at a time.

## Interface
Parameters:
- ROM_AW, 7, ROM address width
- ROM_DW, 16, ROM word width (fixed at 16; the byte split assumes it)
- ROM_LATENCY, 1, cycles from a stable rom_address at the ROM input to valid rom_q (legal range 1..3)
- DUMP_LEN, 128, words sent per dump, starting at address 0 (1..2^ROM_AW)

Ports (one clock; reset is synchronous and active-high):
- CLK in 1: system clock; every register is clocked on its rising edge
- RST in 1: synchronous, active-high reset
- rd_req in 1: single-word read request, sampled only in IDLE
- rd_addr in 7: address for rd_req
- rd_data out 16: captured ROM word
- rd_valid out 1: one-cycle pulse; rd_data is valid while it is high
- dump_start in 1: start a table dump, sampled only in IDLE
- tx_data out 8: byte to the comm transmitter
- tx_valid out 1: byte available
- tx_ready in 1: transmitter accepts the byte
- dump_done out 1: one-cycle pulse after the last checksum byte is accepted
- busy out 1: high in every state except IDLE
- rom_address out 7: registered address to the ROM
- rom_q in 16: ROM data

## Operation
- FSM states: IDLE, RD_WAIT, RD_OUT, DMP_WAIT, TX_HI, TX_LO, CK_HI, CK_LO, DONE.
- IDLE:
  - rd_req=1: rom_address<=rd_addr, latency counter<=ROM_LATENCY, go to RD_WAIT.
  - Otherwise, dump_start=1: word index<=0, checksum<=0, rom_address<=0, counter<=ROM_LATENCY, go to DMP_WAIT.
  - If both are asserted in the same cycle, rd_req wins and dump_start is dropped.
- RD_WAIT: the counter decrements each cycle. When it reaches 1, capture rom_q into rd_data and go to RD_OUT.
- RD_OUT: rd_valid=1 for exactly one cycle, then return to IDLE.
- DMP_WAIT: same counting. At capture, store rom_q in the word register, set checksum<=checksum+rom_q (mod 2^16), then go to TX_HI.
- TX_HI: tx_data=word[15:8], tx_valid=1. On tx_ready, go to TX_LO.
- TX_LO: tx_data=word[7:0], tx_valid=1. On tx_ready:
  - if index=DUMP_LEN-1, go to CK_HI;
  - otherwise index++, rom_address<=index+1, counter<=ROM_LATENCY, go to DMP_WAIT.
- CK_HI / CK_LO: send checksum[15:8] then checksum[7:0], with the same handshake as TX_HI / TX_LO. Acceptance of CK_LO goes to DONE.
- DONE: dump_done=1 for one cycle, then return to IDLE.
- Handshake rules:
  - Once tx_valid is raised, tx_valid and tx_data stay stable until the cycle in which tx_ready=1.
  - A byte transfers on any edge where tx_valid and tx_ready are both high.
  - tx_ready is ignored while tx_valid=0.
- rd_req and dump_start are ignored while busy. They are not queued.
- rd_data holds its last captured value between reads. Dump captures do not modify it.
- Index width is ROM_AW+1 bits, so DUMP_LEN=128 does not wrap.

## Timing
- Reset values: rom_address=0, rd_data=0, rd_valid=0, tx_data=0, tx_valid=0, dump_done=0, busy=0, state=IDLE.
- Reset mid-operation: RST asserted in cycle n forces all of the above at the edge ending cycle n. tx_valid is low from cycle n+1, even if a byte was unaccepted. There is no partial-dump resume.
- Single-read latency: rd_req high in cycle 0 → rom_address valid in cycle 1 → capture at the end of cycle ROM_LATENCY → rd_valid in cycle ROM_LATENCY+1. That is 2 cycles for ROM_LATENCY=1.
- Back-to-back reads: the next rd_req is accepted in the cycle after rd_valid.
- Dump with tx_ready held high: each word costs ROM_LATENCY+2 cycles. The total is DUMP_LEN×(ROM_LATENCY+2)+4 cycles from dump_start to dump_done inclusive of DONE.
- busy rises the cycle after the request is accepted and falls the cycle after rd_valid or dump_done.

## Structure
- Shared package: FSM state encoding constants, ROM_AW/ROM_DW defaults, and the checksum width constant, so the comm-side decoder uses the same values.
- One natural sub-module, rom_lat_ctr: a latency down-counter with load and done outputs. It is shared by the read path and the dump path.
- The ROM itself is instantiated outside this block, at the same hierarchy level.

## Test plan
- ROM model preloaded with word[a] = {a, ~a}, ROM_LATENCY=1. Set rd_addr=5 and pulse rd_req → rd_valid exactly 2 cycles later with rd_data=0x05FA; busy high for 2 cycles.
- Pulse dump_start with tx_ready=1 constantly → 258 bytes arrive in address order 0x00,0xFF,0x01,0xFE,…. The final two bytes equal sum(word[a]) mod 2^16. dump_done pulses once at cycle 3×128+4.
- During a dump, hold tx_ready=0 for 10 cycles in TX_HI, then random backpressure → tx_data stable while stalled; no byte dropped or duplicated.
- rd_req and dump_start asserted in the same IDLE cycle → single read performed, no bytes emitted. A rd_req issued while busy is ignored, and rd_data does not change.
- Assert RST during TX_LO of word 40 → tx_valid=0 and busy=0 the next cycle. A new dump restarts from address 0 with a fresh checksum.
- Regress with ROM_LATENCY=3 and DUMP_LEN=1 → read latency is 4 cycles; the dump emits 4 bytes, and the checksum equals word[0].

Source files
------------

// File: rtl/version_rom_seq_pkg.sv
// version_rom_seq_pkg: shared FSM encoding, ROM geometry defaults and checksum width
package version_rom_seq_pkg;
  localparam int ROM_AW_DEF = 7;
  localparam int ROM_DW_DEF = 16;
  localparam int CK_W = 16;
  typedef enum logic [3:0] {
    IDLE, RD_WAIT, RD_OUT, DMP_WAIT, TX_HI, TX_LO, CK_HI, CK_LO, DONE
  } state_t;
endpackage

// File: rtl/version_rom_seq_rom_lat_ctr.sv
// rom_lat_ctr: ROM latency down-counter, done while the count sits at 1
module rom_lat_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] init,
  output logic         done
);
  logic [W-1:0] cnt;
  // load restarts the wait, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == W'(1);
endmodule

// File: rtl/version_rom_seq.sv
// version_rom_seq: arbitrates ROM access between single reads and a byte-streamed table dump
module version_rom_seq
  import version_rom_seq_pkg::*;
#(
  parameter int ROM_AW = ROM_AW_DEF,
  parameter int ROM_DW = ROM_DW_DEF,
  parameter int ROM_LATENCY = 1,
  parameter int DUMP_LEN = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rd_req,
  input  logic [ROM_AW-1:0] rd_addr,
  output logic [ROM_DW-1:0] rd_data,
  output logic              rd_valid,
  input  logic              dump_start,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              dump_done,
  output logic              busy,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [ROM_DW-1:0] rom_q
);
  localparam int CW = $clog2(ROM_LATENCY + 1);
  localparam logic [ROM_AW:0] LAST = (ROM_AW + 1)'(DUMP_LEN - 1);
  state_t state;
  logic [ROM_AW:0] idx;
  logic [ROM_DW-1:0] word;
  logic [CK_W-1:0] cksum;
  logic ctr_load, ctr_done;
  assign ctr_load = (state == IDLE && (rd_req || dump_start)) ||
                    (state == TX_LO && tx_ready && idx != LAST);
  rom_lat_ctr #(.W(CW)) u_ctr (
    .clk (CLK),
    .rst (RST),
    .load(ctr_load),
    .init(CW'(ROM_LATENCY)),
    .done(ctr_done)
  );
  // sequencer: every output is registered and set on the transition into its state
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rom_address <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      dump_done <= 1'b0;
      busy <= 1'b0;
      idx <= '0;
      word <= '0;
      cksum <= '0;
    end else begin
      rd_valid <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            rom_address <= rd_addr;
            busy <= 1'b1;
            state <= RD_WAIT;
          end else if (dump_start) begin
            rom_address <= '0;
            idx <= '0;
            cksum <= '0;
            busy <= 1'b1;
            state <= DMP_WAIT;
          end
        end
        RD_WAIT: if (ctr_done) begin
          rd_data <= rom_q;
          rd_valid <= 1'b1;
          state <= RD_OUT;
        end
        RD_OUT: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        DMP_WAIT: if (ctr_done) begin
          word <= rom_q;
          cksum <= cksum + rom_q;
          tx_data <= rom_q[15:8];
          tx_valid <= 1'b1;
          state <= TX_HI;
        end
        TX_HI: if (tx_ready) begin
          tx_data <= word[7:0];
          state <= TX_LO;
        end
        TX_LO: if (tx_ready) begin
          if (idx == LAST) begin
            tx_data <= cksum[15:8];
            state <= CK_HI;
          end else begin
            idx <= idx + 1'b1;
            rom_address <= ROM_AW'(idx + 1'b1);
            tx_valid <= 1'b0;
            state <= DMP_WAIT;
          end
        end
        CK_HI: if (tx_ready) begin
          tx_data <= cksum[7:0];
          state <= CK_LO;
        end
        CK_LO: if (tx_ready) begin
          tx_valid <= 1'b0;
          dump_done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_version_rom_seq.sv
// tb_version_rom_seq: randomized checks of reads and dumps against a ROM-content reference model
module tb_version_rom_seq;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic rd_req = 1'b0;
  logic [6:0] rd_addr = '0;
  logic dump_start = 1'b0;
  logic tx_ready = 1'b0;
  logic [15:0] rd_data_a, rd_data_b, rom_q_a, rom_q_b;
  logic rd_valid_a, rd_valid_b, tx_valid_a, tx_valid_b, dump_done_a, dump_done_b, busy_a, busy_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [6:0] rom_address_a, rom_address_b, ad1, ad2;
  logic [15:0] o_rd_data;
  logic o_rd_valid, o_tx_valid, o_dump_done, o_busy;
  logic [7:0] o_tx_data;
  logic [6:0] o_rom_address;
  bit sel = 1'b0;
  int lat = 1;
  int dlen = 128;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [15:0] rom_word(input logic [6:0] a);
    return {{1'b0, a}, ~{1'b0, a}};
  endfunction

  assign rom_q_a = rom_word(rom_address_a);
  always @(posedge CLK) begin
    ad1 <= rom_address_b;
    ad2 <= ad1;
  end
  assign rom_q_b = rom_word(ad2);

  version_rom_seq #(.ROM_LATENCY(1), .DUMP_LEN(128)) dut_a (
    .CLK(CLK), .RST(RST), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .dump_start(dump_start), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready), .dump_done(dump_done_a), .busy(busy_a), .rom_address(rom_address_a),
    .rom_q(rom_q_a)
  );
  version_rom_seq #(.ROM_LATENCY(3), .DUMP_LEN(1)) dut_b (
    .CLK(CLK), .RST(RST), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .dump_start(dump_start), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready), .dump_done(dump_done_b), .busy(busy_b), .rom_address(rom_address_b),
    .rom_q(rom_q_b)
  );

  assign o_rd_data = sel ? rd_data_b : rd_data_a;
  assign o_rd_valid = sel ? rd_valid_b : rd_valid_a;
  assign o_tx_data = sel ? tx_data_b : tx_data_a;
  assign o_tx_valid = sel ? tx_valid_b : tx_valid_a;
  assign o_dump_done = sel ? dump_done_b : dump_done_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_rom_address = sel ? rom_address_b : rom_address_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    rd_req = 1'b0;
    dump_start = 1'b0;
    tx_ready = 1'b0;
    cyc();
    cyc();
    check("rst_rom_address", o_rom_address, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_dump_done", o_dump_done, 0);
    check("rst_busy", o_busy, 0);
    RST = 1'b0;
    cyc();
  endtask

  task automatic do_read(input logic [6:0] a, input bit both);
    int vcyc, bcnt, txc;
    logic [15:0] exp, cap;
    exp = rom_word(a);
    cap = '0;
    vcyc = -1;
    bcnt = 0;
    txc = 0;
    rd_req = 1'b1;
    rd_addr = a;
    dump_start = both;
    tx_ready = 1'b1;
    for (int k = 1; k <= 12 && vcyc < 0; k++) begin
      cyc();
      dump_start = 1'b0;
      rd_addr = a ^ 7'h2a;
      if (o_busy) bcnt++;
      if (o_tx_valid) txc++;
      if (o_rd_valid) begin
        vcyc = k;
        cap = o_rd_data;
        rd_req = 1'b0;
      end
    end
    check("rd_latency", vcyc, lat + 1);
    check("rd_data", cap, exp);
    check("rd_busy_cycles", bcnt, lat + 1);
    cyc();
    check("rd_idle_busy", o_busy, 0);
    check("rd_hold", o_rd_data, exp);
    check("rd_single_pulse", o_rd_valid, 0);
    if (both) check("rd_no_tx", txc + int'(o_tx_valid), 0);
  endtask

  task automatic do_dump(input bit bp, input int abort_at);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [15:0] sum, w, rd_before, ck_got;
    logic [7:0] pd;
    logic pv;
    int stall, dcyc, unstable, rdv, bad, n;
    sum = '0;
    for (int a = 0; a < dlen; a++) begin
      w = rom_word(7'(a));
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      sum += w;
    end
    exp_q.push_back(sum[15:8]);
    exp_q.push_back(sum[7:0]);
    rd_before = o_rd_data;
    rd_req = 1'b0;
    dump_start = 1'b1;
    tx_ready = !bp;
    stall = -1;
    dcyc = -1;
    unstable = 0;
    rdv = 0;
    pv = 1'b0;
    pd = '0;
    for (int k = 1; k <= 20000 && dcyc < 0; k++) begin
      cyc();
      dump_start = 1'b0;
      rd_req = 1'b1;
      rd_addr = 7'($urandom);
      if (pv && (!o_tx_valid || o_tx_data !== pd)) unstable++;
      if (o_rd_valid) rdv++;
      if (o_dump_done) begin
        dcyc = k;
        rd_req = 1'b0;
      end
      if (bp) begin
        if (stall < 0 && o_tx_valid) stall = 10;
        tx_ready = stall > 0 ? 1'b0 : 1'($urandom_range(0, 1));
        if (stall > 0) stall--;
      end else tx_ready = 1'b1;
      if (abort_at >= 0 && o_tx_valid && got_q.size() == abort_at) begin
        check("abort_byte", o_tx_data, exp_q[abort_at]);
        RST = 1'b1;
        tx_ready = 1'b0;
        rd_req = 1'b0;
        cyc();
        RST = 1'b0;
        check("abort_tx_valid", o_tx_valid, 0);
        check("abort_busy", o_busy, 0);
        return;
      end
      if (o_tx_valid && tx_ready) got_q.push_back(o_tx_data);
      pv = o_tx_valid && !tx_ready;
      pd = o_tx_data;
    end
    check("dump_done_seen", dcyc >= 0, 1);
    if (!bp) check("dump_cycles", dcyc + 1, dlen * (lat + 2) + 4);
    check("dump_nbytes", got_q.size(), exp_q.size());
    n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    bad = 0;
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) bad++;
    check("dump_bytes_bad", bad, 0);
    ck_got = got_q.size() >= 2 ? {got_q[got_q.size() - 2], got_q[got_q.size() - 1]} : 16'h0;
    check("dump_cksum", ck_got, sum);
    check("tx_stable_violations", unstable, 0);
    check("rd_while_busy", rdv, 0);
    cyc();
    check("done_pulse_once", o_dump_done, 0);
    check("done_busy_low", o_busy, 0);
    check("rd_data_kept", o_rd_data, rd_before);
  endtask

  initial begin
    sel = 1'b0;
    lat = 1;
    dlen = 128;
    do_reset();
    do_read(7'd5, 1'b0);
    for (int i = 0; i < 4; i++) do_read(7'($urandom), 1'b0);
    do_read(7'($urandom), 1'b1);
    do_dump(1'b0, -1);
    do_dump(1'b1, -1);
    do_dump(1'b0, 81);
    do_dump(1'b0, -1);
    sel = 1'b1;
    lat = 3;
    dlen = 1;
    do_reset();
    do_read(7'd5, 1'b0);
    do_read(7'($urandom), 1'b0);
    do_dump(1'b0, -1);
    do_dump(1'b1, -1);
    do_read(7'($urandom), 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
